i2s_stream_tx: RTL
==================

Name: i2s_stream_tx

Overview:
- Parametrised I2S audio transmitter: successor to the fixed 32-bit left/right shift-register pair that drives the audio codec.
- Generates MCLK, SCLK and LRCLK from the system clock. Serialises stereo samples that arrive over a valid/ready stream.
- Buffers samples in an internal FIFO, so producers (frame RAM reader, tone generator) need not track codec timing.
- Sits between the sample source and the codec pins on the Arduino header.

Parameters:
- SAMPLE_W, 16, bits per channel sample (two's complement); legal range 1..SLOT_W-1.
- SLOT_W, 32, SCLK periods per channel slot; one frame is 2*SLOT_W SCLK periods.
- FIFO_DEPTH, 8, stereo pairs buffered; power of two, >=2.
- SCLK_HALF, 8, Clk cycles per SCLK half-period; >=2.
- MCLK_DIV, 4, Clk cycles per MCLK period; even, >=2.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run serial clocks and frames.
- in_valid  in  1  a sample pair is offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_left  in  SAMPLE_W  left sample.
- in_right  in  SAMPLE_W  right sample.
- level  out  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- underrun  out  1  sticky: a frame started with the FIFO empty.
- underrun_clr  in  1  synchronous clear of underrun.
- mclk  out  1  codec master clock.
- sclk  out  1  bit clock.
- lrclk  out  1  word select; 0 = left.
- sd  out  1  serial data.

Behaviour:
- Reset (async): FIFO empty, level=0, in_ready=1, underrun=0, mclk=sclk=lrclk=sd=0, all counters 0, current frame words 0.
- mclk: free-running once out of reset, independent of enable.
  - Toggles every MCLK_DIV/2 Clk cycles.
  - First rising edge MCLK_DIV/2 cycles after Reset deasserts.
- enable=0:
  - Divider and bit counters held at 0; sclk, lrclk and sd held at 0.
  - No FIFO pops. Pushes are still accepted.
- enable=1:
  - Half-period counter counts 0..SCLK_HALF-1; sclk toggles on wrap.
  - The first sclk rise comes SCLK_HALF cycles after enable rises.
  - Bit index b = 0..2*SLOT_W-1 advances on every sclk falling edge. lrclk, sd and b change only at sclk falling edges.
- Frame boundary (b wraps to 0, including the first frame after enable):
  - If level>0, pop the FIFO head into the current left/right words.
  - Else load zeros and set underrun.
- Slot mapping:
  - lrclk = 0 for b<SLOT_W, 1 otherwise.
  - Slot bit s=0 drives sd=0 (I2S one-bit delay).
  - s=1..SAMPLE_W drive the sample, MSB first.
  - s>SAMPLE_W drive 0.
- Frame length = 2*SLOT_W*2*SCLK_HALF Clk cycles (1024 at defaults; 48.83 kHz from 50 MHz).
- FIFO accepts on in_valid&&in_ready. Push and pop in the same cycle: level unchanged.
- Push into an empty FIFO in the same cycle as a frame boundary:
  - Counts as underrun; there is no bypass.
  - The pushed pair plays in the next frame.
- When full, in_ready=0. A pop that cycle does not enable a same-cycle push.
- underrun_clr coinciding with a new underrun event: set wins.
- Reset asserted mid-frame:
  - Immediately returns everything to reset values; FIFO contents are discarded.
  - A new frame starts from b=0 after release.

Optional Feature:
- I2S_TX_VOLUME_EN.
  - Defined: adds input vol_shift, width 4. Each popped sample is arithmetically right-shifted by vol_shift before serialisation. vol_shift is sampled at the frame boundary; values >=SAMPLE_W give all sign bits.
  - Undefined: port absent; samples are transmitted unmodified.

Test Plan:
- Basic frame:
  - Stimulus: defaults; release reset, push L=16'hA5C3, R=16'h0F01, then raise enable.
  - Response, left slot (lrclk=0 for 512 cycles): sd sampled at sclk rises is 0, then 1010010111000011, then 15 zeros.
  - Response, right slot: 0, then 0000111100000001, then 15 zeros. level returns 0 at the first boundary.
- Underrun:
  - Stimulus: continue with no pushes.
  - Response: second frame sd all 0 and underrun=1. Pulse underrun_clr and underrun=0. Next empty frame sets it again.
- Back-pressure:
  - Stimulus: enable=0, push 9 pairs back-to-back.
  - Response: level=8, in_ready=0 after the 8th push, 9th pair dropped. Enable, then first frame plays pair 1 and level=7.
- Clocks:
  - Response: mclk period 4 Clk, sclk period 16 Clk, lrclk period 1024 Clk.
  - lrclk edges coincide with sclk falling edges. With enable=0, sclk and lrclk stay 0 while mclk runs.
- Reset mid-frame:
  - Stimulus: assert Reset at b=20 with 3 pairs queued.
  - Response: all outputs 0 in the same cycle, level=0 and underrun=0. After release, enable gives an empty frame and underrun=1.
- Volume (I2S_TX_VOLUME_EN):
  - Stimulus: vol_shift=2, L=16'h8000, R=16'h0040.
  - Response: serialised L=16'hE000, R=16'h0010.

Source files
------------

// File: rtl/i2s_stream_tx.sv
// I2S transmitter: MCLK/SCLK/LRCLK generation, stereo FIFO fed by a valid/ready stream.
// Optional build macro I2S_TX_VOLUME_EN adds vol_shift (arithmetic attenuation of popped samples).
module i2s_stream_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int SCLK_HALF  = 8,
    parameter int MCLK_DIV   = 4
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            enable,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SAMPLE_W-1:0]             in_left,
    input  logic [SAMPLE_W-1:0]             in_right,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            underrun,
    input  logic                            underrun_clr,
`ifdef I2S_TX_VOLUME_EN
    input  logic [3:0]                      vol_shift,
`endif
    output logic                            mclk,
    output logic                            sclk,
    output logic                            lrclk,
    output logic                            sd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(2 * SLOT_W);
    localparam int HW = $clog2(SCLK_HALF);
    localparam int MW = $clog2(MCLK_DIV);

    localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV / 2 - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(SCLK_HALF - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] SLOT_B    = BW'(SLOT_W);
    localparam logic [BW-1:0] SW_B      = BW'(SAMPLE_W);
    localparam logic [AW:0]   FULL_L    = (AW + 1)'(FIFO_DEPTH);

    logic [MW-1:0]       mcnt;
    logic [HW-1:0]       hcnt;
    logic [BW-1:0]       b, b_next, s_next;
    logic                run, start, fall, boundary;
    logic                lr_next, sd_next, push, pop, empty;
    logic [SAMPLE_W-1:0] cur_left, cur_right, word, shifted, pop_l, pop_r;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];

    // Master clock runs regardless of enable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mcnt <= '0;
            mclk <= 1'b0;
        end else if (mcnt == MCLK_LAST) begin
            mcnt <= '0;
            mclk <= ~mclk;
        end else begin
            mcnt <= mcnt + 1'b1;
        end
    end

    assign start    = enable && !run;
    assign fall     = enable && sclk && (hcnt == H_LAST);
    assign boundary = start || (fall && (b == B_LAST));
    assign empty    = (level == '0);
    assign in_ready = (level != FULL_L);
    assign push     = in_valid && in_ready;
    assign pop      = boundary && !empty;

    // Next bit position and the serial bit it carries; s=0 is the I2S one-bit delay.
    always_comb begin
        b_next  = (b == B_LAST) ? '0 : b + 1'b1;
        lr_next = (b_next >= SLOT_B);
        s_next  = lr_next ? b_next - SLOT_B : b_next;
        word    = lr_next ? cur_right : cur_left;
        shifted = word << (s_next - 1'b1);
        sd_next = (s_next != '0) && (s_next <= SW_B) && shifted[SAMPLE_W-1];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hcnt  <= '0;
            sclk  <= 1'b0;
            b     <= '0;
            lrclk <= 1'b0;
            sd    <= 1'b0;
            run   <= 1'b0;
        end else if (!enable) begin
            hcnt  <= '0;
            sclk  <= 1'b0;
            b     <= '0;
            lrclk <= 1'b0;
            sd    <= 1'b0;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                sclk <= ~sclk;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
            if (fall) begin
                b     <= b_next;
                lrclk <= lr_next;
                sd    <= sd_next;
            end
        end
    end

    always_comb begin
`ifdef I2S_TX_VOLUME_EN
        pop_l = $signed(mem_l[rd_ptr]) >>> vol_shift;
        pop_r = $signed(mem_r[rd_ptr]) >>> vol_shift;
`else
        pop_l = mem_l[rd_ptr];
        pop_r = mem_r[rd_ptr];
`endif
    end

    // A frame starting on an empty FIFO plays silence; a same-cycle push is not bypassed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_left  <= '0;
            cur_right <= '0;
            underrun  <= 1'b0;
        end else begin
            if (boundary) begin
                cur_left  <= pop ? pop_l : '0;
                cur_right <= pop ? pop_r : '0;
            end
            if (boundary && empty)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_l[wr_ptr] <= in_left;
            mem_r[wr_ptr] <= in_right;
        end
    end
endmodule
